// File: rtl/cbus_tx_prbs_test_ctrl.sv
// cbus_tx_prbs_test_ctrl: sequences a PRBS generator through seed, run and done, with bit/error counting and error injection.
module cbus_tx_prbs_test_ctrl #(
   parameter int N     = 31,
   parameter int CNT_W = 32,
   parameter int PER_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic [PER_W-1:0] cfg_err_period,
   input  logic             inj_single,
   input  logic             tx_ready,
   output logic             prbs_rst,
   output logic             prbs_ce,
   output logic             prbs_din,
   output logic             prbs_sel,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   localparam int SW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [SW-1:0]    seed_q, seed_d;
   logic [PER_W-1:0] per_q, per_d, period_q, period_d;
   logic [CNT_W-1:0] len_q, len_d, bit_q, bit_d, err_q, err_d;
   logic             pend_q, pend_d, abort_q, abort_d;
   logic             prbs_rst_q, prbs_sel_q, busy_q, done_q;
   logic             fire, per_hit;
   assign prbs_rst = prbs_rst_q;
   assign prbs_sel = prbs_sel_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign aborted  = abort_q;
   assign bit_cnt  = bit_q;
   assign err_cnt  = err_q;
   always_comb begin
      fire     = (state_q == RUN) && tx_ready;
      per_hit  = (period_q != '0) && (per_q == period_q - PER_W'(1));
      prbs_ce  = (state_q == SEED) || fire;
      prbs_din = fire && (per_hit || pend_q);
      state_d  = state_q;
      seed_d   = seed_q;
      per_d    = per_q;
      period_d = period_q;
      len_d    = len_q;
      bit_d    = bit_q;
      err_d    = err_q;
      abort_d  = abort_q;
      // a request arriving on the bit that consumes the previous one stays pending
      pend_d   = (state_q == IDLE) ? 1'b0 : ((pend_q && !fire) || inj_single);
      if (state_q == IDLE && start && !stop) begin
         state_d  = SEED;
         seed_d   = '0;
         per_d    = '0;
         period_d = cfg_err_period;
         len_d    = cfg_len;
         bit_d    = '0;
         err_d    = '0;
         abort_d  = 1'b0;
      end
      if (state_q == SEED) begin
         seed_d  = seed_q + SW'(1);
         state_d = stop ? DONE : (seed_q == SW'(N - 1)) ? RUN : SEED;
         abort_d = stop ? 1'b1 : abort_q;
      end
      if (fire) begin
         bit_d = (&bit_q) ? bit_q : bit_q + CNT_W'(1);
         err_d = (prbs_din && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
         per_d = (period_q == '0 || per_hit) ? '0 : per_q + PER_W'(1);
      end
      if (state_q == RUN && (stop || (fire && len_q != '0 && bit_d == len_q))) begin
         state_d = DONE;
         abort_d = stop;
      end
      if (state_q == DONE) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         seed_q     <= '0;
         per_q      <= '0;
         period_q   <= '0;
         len_q      <= '0;
         bit_q      <= '0;
         err_q      <= '0;
         pend_q     <= 1'b0;
         abort_q    <= 1'b0;
         prbs_rst_q <= 1'b0;
         prbs_sel_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         per_q      <= per_d;
         period_q   <= period_d;
         len_q      <= len_d;
         bit_q      <= bit_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         abort_q    <= abort_d;
         prbs_rst_q <= state_d == SEED;
         prbs_sel_q <= state_d == RUN;
         busy_q     <= state_d != IDLE;
         done_q     <= state_d == DONE;
      end
   end
endmodule

// File: tb/tb_cbus_tx_prbs_test_ctrl.sv
// tb_cbus_tx_prbs_test_ctrl: checks the PRBS test controller cycle by cycle against a behavioural model.
module tb_cbus_tx_prbs_test_ctrl;
   localparam int N = 7, CW = 10, PW = 4;
   localparam int MAXC = (1 << CW) - 1;
   localparam int P_IDLE = 0, P_SEED = 1, P_RUN = 2, P_DONE = 3;
   logic clk = 1'b0;
   logic rst, start, stop, inj_single, tx_ready;
   logic [CW-1:0] cfg_len;
   logic [PW-1:0] cfg_err_period;
   logic prbs_rst, prbs_ce, prbs_din, prbs_sel, busy, done, aborted;
   logic [CW-1:0] bit_cnt, err_cnt;
   int n_cmp = 0, n_fail = 0;
   int ph, seed_left, m_bit, m_err, m_len, m_per;
   longint m_tx;
   bit m_pend, m_ab;
   int rst_hi, sel_hi, done_hi, din_hi, din_bad;

   cbus_tx_prbs_test_ctrl #(.N(N), .CNT_W(CW), .PER_W(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_len(cfg_len),
      .cfg_err_period(cfg_err_period), .inj_single(inj_single), .tx_ready(tx_ready),
      .prbs_rst(prbs_rst), .prbs_ce(prbs_ce), .prbs_din(prbs_din), .prbs_sel(prbs_sel),
      .busy(busy), .done(done), .aborted(aborted), .bit_cnt(bit_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_din();
      return ph == P_RUN && tx_ready && (m_pend || (m_per != 0 && (m_tx + 1) % m_per == 0));
   endfunction

   task automatic clr_stats();
      rst_hi = 0; sel_hi = 0; done_hi = 0; din_hi = 0; din_bad = 0;
   endtask

   task automatic step(input bit r, input bit s, input bit p, input bit inj, input bit tx);
      bit d;
      @(negedge clk);
      rst = r; start = s; stop = p; inj_single = inj; tx_ready = tx;
      #1;
      d = exp_din();
      chk("prbs_rst", prbs_rst, ph == P_SEED);
      chk("prbs_sel", prbs_sel, ph == P_RUN);
      chk("busy", busy, ph != P_IDLE);
      chk("done", done, ph == P_DONE);
      chk("prbs_ce", prbs_ce, ph == P_SEED || (ph == P_RUN && tx));
      chk("prbs_din", prbs_din, d);
      chk("aborted", aborted, m_ab);
      chk("bit_cnt", bit_cnt, m_bit);
      chk("err_cnt", err_cnt, m_err);
      rst_hi += int'(prbs_rst); sel_hi += int'(prbs_sel); done_hi += int'(done);
      if (prbs_din && tx_ready) begin
         din_hi++;
         if ((int'(bit_cnt) + 1) % 10 != 0) din_bad++;
      end
      @(posedge clk);
      if (r) begin
         ph = P_IDLE; m_bit = 0; m_err = 0; m_ab = 0; m_pend = 0;
      end else if (ph == P_IDLE) begin
         m_pend = 0;
         if (s && !p) begin
            ph = P_SEED; seed_left = N; m_len = int'(cfg_len); m_per = int'(cfg_err_period);
            m_bit = 0; m_err = 0; m_ab = 0; m_tx = 0;
         end
      end else if (ph == P_SEED) begin
         m_pend |= inj;
         if (p) begin
            ph = P_DONE; m_ab = 1;
         end else begin
            seed_left--;
            if (seed_left == 0) ph = P_RUN;
         end
      end else if (ph == P_RUN) begin
         if (tx) begin
            m_tx++;
            if (m_bit < MAXC) m_bit++;
            if (d && m_err < MAXC) m_err++;
            m_pend = 0;
         end
         m_pend |= inj;
         if (p) begin
            ph = P_DONE; m_ab = 1;
         end else if (tx && m_len != 0 && m_bit == m_len) ph = P_DONE;
      end else begin
         m_pend |= inj;
         ph = P_IDLE;
      end
      #1;
   endtask

   task automatic run_until_idle(input int maxc, input bit toggle);
      for (int i = 0; i < maxc && ph != P_IDLE; i++) step(0, 0, 0, 0, toggle ? i[0] : 1'b1);
      if (ph != P_IDLE) chk("timeout_idle", 0, 1);
   endtask

   task automatic run_to_bit(input int target, input int maxc);
      for (int i = 0; i < maxc && m_bit < target; i++) step(0, 0, 0, 0, 1);
      if (m_bit < target) chk("timeout_bits", m_bit, target);
   endtask

   initial begin
      rst = 1; start = 0; stop = 0; inj_single = 0; tx_ready = 0;
      cfg_len = '0; cfg_err_period = '0;
      ph = P_IDLE; m_bit = 0; m_err = 0; m_ab = 0; m_pend = 0; m_tx = 0;
      m_len = 0; m_per = 0; seed_left = 0;
      repeat (2) @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0);
      chk("reset_busy", busy, 0);
      chk("reset_bits", bit_cnt, 0);
      step(0, 1, 1, 0, 1);
      chk("start_stop_ignored", busy, 0);

      clr_stats();
      cfg_len = 20; cfg_err_period = 0;
      step(0, 1, 0, 0, 1);
      cfg_len = 3; cfg_err_period = 2;
      run_until_idle(100, 0);
      chk("seed_cycles", rst_hi, 7);
      chk("sel_cycles", sel_hi, 20);
      chk("done_pulses", done_hi, 1);
      chk("len20_bits", bit_cnt, 20);
      chk("len20_errs", err_cnt, 0);

      clr_stats();
      cfg_len = 100; cfg_err_period = 10;
      step(0, 1, 0, 0, 0);
      run_until_idle(400, 1);
      chk("per10_din_count", din_hi, 10);
      chk("per10_din_off_grid", din_bad, 0);
      chk("per10_errs", err_cnt, 10);
      chk("per10_bits", bit_cnt, 100);

      clr_stats();
      cfg_len = 0; cfg_err_period = 0;
      step(0, 1, 0, 0, 1);
      run_to_bit(250, 400);
      cfg_len = 5;
      step(0, 1, 0, 0, 1);
      chk("restart_ignored_busy", busy, 1);
      run_to_bit(499, 400);
      step(0, 0, 1, 0, 1);
      chk("stop_done", done, 1);
      chk("stop_aborted", aborted, 1);
      chk("stop_bits", bit_cnt, 500);
      step(0, 0, 0, 0, 1);
      chk("stop_idle_busy", busy, 0);

      cfg_len = 30; cfg_err_period = 5;
      step(0, 1, 0, 0, 1);
      run_to_bit(4, 40);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      chk("coinc_errs", err_cnt, 1);
      chk("coinc_bits", bit_cnt, 5);
      run_until_idle(60, 0);
      chk("coinc_final_errs", err_cnt, 6);

      clr_stats();
      cfg_len = 40; cfg_err_period = 0;
      step(0, 1, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      chk("rst_seed_prbs_rst", prbs_rst, 0);
      chk("rst_seed_busy", busy, 0);
      step(0, 1, 0, 0, 1);
      run_to_bit(10, 40);
      step(1, 0, 0, 0, 1);
      chk("rst_run_bits", bit_cnt, 0);
      chk("rst_run_sel", prbs_sel, 0);
      repeat (3) step(0, 0, 0, 0, 1);
      chk("rst_no_done", done_hi, 0);
      step(0, 1, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      chk("seed_stop_done", done, 1);
      chk("seed_stop_aborted", aborted, 1);
      chk("seed_stop_bits", bit_cnt, 0);
      step(0, 0, 0, 0, 0);

      cfg_len = 0; cfg_err_period = 1;
      step(0, 1, 0, 0, 1);
      for (int i = 0; i < 1100 && m_tx < 1030; i++) step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      chk("sat_bits", bit_cnt, MAXC);
      chk("sat_errs", err_cnt, MAXC);
      step(0, 0, 0, 0, 1);

      for (int i = 0; i < 4000; i++) begin
         cfg_len = CW'($urandom_range(0, 60));
         cfg_err_period = PW'($urandom_range(0, 15));
         step($urandom % 200 == 0, $urandom % 20 == 0, $urandom % 40 == 0,
              $urandom % 10 == 0, $urandom % 10 < 7);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
